// File: rtl/vga_timing_param.sv
// Parametrised VGA timing generator: H/V counters, blanking, sync, DE and line/frame pulses.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_param #(
    parameter int CNT_W    = 11,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hblnk,
    output logic             vblnk,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line_start,
    output logic             frame_start,
    output logic [15:0]      frame_cnt
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] HA_L   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] VA_L   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    generate
        if (H_TOT > 2**CNT_W || V_TOT > 2**CNT_W)
            $error("vga_timing_param: CNT_W too small for H_TOT/V_TOT");
        if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0)
            $error("vga_timing_param: zero-length timing parameter");
    endgenerate

    // run is clear until the first enabled edge, which presents (0,0) instead of advancing
    logic             run;
    logic [CNT_W-1:0] nh, nv;

    always_comb begin
        nh = hcount + 1'b1;
        nv = vcount;
        if (restart || !run) begin
            nh = '0;
            nv = '0;
        end else if (hcount == H_LAST) begin
            nh = '0;
            nv = (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            run         <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (restart || en) begin
            run         <= 1'b1;
            hcount      <= nh;
            vcount      <= nv;
            hblnk       <= (nh >= HA_L);
            vblnk       <= (nv >= VA_L);
            hsync       <= (nh >= HS_BEG && nh <= HS_END) ? HS_POL : ~HS_POL;
            vsync       <= (nv >= VS_BEG && nv <= VS_END) ? VS_POL : ~VS_POL;
            de          <= (nh < HA_L) && (nv < VA_L);
            line_start  <= (nh == '0);
            frame_start <= (nh == '0) && (nv == '0);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // only a natural wrap counts; restart and the initial (0,0) presentation do not
    logic wrap;
    assign wrap = run && en && !restart && (hcount == H_LAST) && (vcount == V_LAST);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst)       frame_cnt <= 16'd0;
        else if (wrap) frame_cnt <= frame_cnt + 16'd1;
    end
`else
    assign frame_cnt = 16'd0;
`endif
endmodule
